// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_ctrl_pkg
//  Description : Shared opcode, ALUOp and FSM state definitions for the
//                multicycle RISC-V main control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE     = 7'b0110011;
    localparam logic [6:0] OP_ITYPE_ALU = 7'b0010011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXEC_R    = 4'd6,
        ST_EXEC_I    = 4'd7,
        ST_ALU_WB    = 4'd8,
        ST_BRANCH    = 4'd9
    } state_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
               (op == OP_ITYPE_ALU) || (op == OP_BRANCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wait_timer
//  Description : Wait-state counter with timeout compare, shared by all
//                memory-access states of the control FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    input  logic clear,
    output logic timeout
);

    // Timeout fires on the cycle whose stall would bring the count to the limit.
    localparam logic [7:0] c_LIMIT = 8'(MEM_WAIT_MAX - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (clear) begin
            r_count <= 8'd0;
        end else if (active && !mem_ready) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign timeout = active && !mem_ready && (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control FSM of the multicycle RISC-V datapath with
//                memory wait-state timeout. Optional retired-instruction
//                counter enabled by defining INSTRET_COUNTER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
`ifdef INSTRET_COUNTER_EN
    output logic [31:0] instret,
`endif
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCSource,
    output logic [2:0] ALUOp,
    output logic       bus_error,
    output logic       illegal_op
);

    state_t r_state;
    state_t w_state_next;
    logic   w_timeout;
    logic   w_wait_active;
    logic   w_timer_clear;
    logic   r_bus_error;
    logic   r_illegal_op;

    assign w_wait_active = (r_state == ST_FETCH) || (r_state == ST_MEM_READ) ||
                           (r_state == ST_MEM_WRITE);
    // A timeout in FETCH re-enters FETCH, so the counter must be cleared explicitly.
    assign w_timer_clear = (w_state_next != r_state) || w_timeout;

    mem_wait_timer #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) u_mem_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (w_wait_active),
        .mem_ready(mem_ready),
        .clear    (w_timer_clear),
        .timeout  (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (mem_ready)      w_state_next = ST_DECODE;
                else if (w_timeout) w_state_next = ST_FETCH;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_state_next = ST_MEM_ADDR;
                    OP_RTYPE:          w_state_next = ST_EXEC_R;
                    OP_ITYPE_ALU:      w_state_next = ST_EXEC_I;
                    OP_BRANCH:         w_state_next = ST_BRANCH;
                    default:           w_state_next = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR:  w_state_next = (opcode == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ: begin
                if (mem_ready)      w_state_next = ST_MEM_WB;
                else if (w_timeout) w_state_next = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                if (mem_ready || w_timeout) w_state_next = ST_FETCH;
            end
            ST_MEM_WB:    w_state_next = ST_FETCH;
            ST_EXEC_R:    w_state_next = ST_ALU_WB;
            ST_EXEC_I:    w_state_next = ST_ALU_WB;
            ST_ALU_WB:    w_state_next = ST_FETCH;
            ST_BRANCH:    w_state_next = ST_FETCH;
            default:      w_state_next = ST_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 1'b0;
        ALUOp       = ALUOP_ADD;
        case (r_state)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            ST_DECODE: begin
                ALUSrcB = 2'b10;
            end
            ST_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ST_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            ST_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALUOP_OR;
            end
            ST_ALU_WB: begin
                RegWrite = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCSource    = 1'b1;
                PCWriteCond = ~zero;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_error  <= 1'b0;
            r_illegal_op <= 1'b0;
        end else begin
            r_bus_error  <= w_timeout;
            r_illegal_op <= (r_state == ST_DECODE) && !is_legal_op(opcode);
        end
    end

    assign bus_error  = r_bus_error;
    assign illegal_op = r_illegal_op;

`ifdef INSTRET_COUNTER_EN
    logic [31:0] r_instret;
    logic        w_retire;

    assign w_retire = (r_state == ST_MEM_WB) || (r_state == ST_ALU_WB) ||
                      (r_state == ST_BRANCH) ||
                      ((r_state == ST_MEM_WRITE) && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= 32'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;
`endif

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM of the multicycle RISC-V datapath, directly upstream of the ALU control decoder.
- Sequences fetch, decode, execute, memory and writeback for lb, sb, bne, R-type (add/and/sll) and ori.
- Drives the 3-bit ALUOp consumed by the ALU control decoder and all datapath enables.
- Supports memory wait states via a ready handshake and a bounded wait timeout.

Parameters:
- MEM_WAIT_MAX, 15, maximum cycles a memory state waits for mem_ready before bus_error; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction[6:0], read from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  PC write if branch condition holds
- IorD  out  1  0=PC addresses memory, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  0=ALUOut, 1=MDR to register file
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=register A
- ALUSrcB  out  2  00=B, 01=constant 4, 10=immediate
- PCSource  out  1  0=ALU result, 1=ALUOut
- ALUOp  out  3  000=add (ld/st/PC), 001=sub (bne), 010=funct decode, 011=or (ori)
- bus_error  out  1  one-cycle pulse on memory wait timeout
- illegal_op  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Moore FSM, state register reset to FETCH asynchronously. Outputs are a combinational decode of the state, qualified by mem_ready where noted. An output not listed for a state is 0.
- Wait counter is 8-bit, reset to 0, and cleared on every state change.
- bus_error and illegal_op are registered and reset to 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000.
  - IRWrite and PCWrite equal mem_ready.
  - On mem_ready -> DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=10, ALUOp=000 (branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 -> MEM_ADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH.
  - Any other opcode -> FETCH, with illegal_op pulsed the next cycle.
- MEM_ADDR:
  - ALUSrcA=1, ALUSrcB=10, ALUOp=000.
  - -> MEM_READ if opcode=0000011, else MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. On mem_ready -> MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1. -> FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. On mem_ready -> FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=010. -> ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=011. -> ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0. -> FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=1.
  - PCWriteCond=~zero (bne taken when operands differ). -> FETCH.
- Wait states (FETCH, MEM_READ, MEM_WRITE):
  - Counter increments each cycle mem_ready=0.
  - When the counter reaches MEM_WAIT_MAX with mem_ready still 0: go to FETCH, pulse bus_error; no IRWrite/PCWrite/RegWrite occurs.
  - mem_ready=1 on the limit cycle wins: the access completes normally.
- Latency without wait states, counting from the FETCH cycle: lb 5 cycles, sb 4, R-type/ori 4, bne 3.
- Reset mid-instruction: abort immediately to FETCH; no partial writeback occurs after rst_n deasserts.

Optional Feature:
- INSTRET_COUNTER_EN
- Defined:
  - Adds output instret (32 bits), reset to 0.
  - Increments by 1 on completion of each instruction: MEM_WB, MEM_WRITE with mem_ready, ALU_WB, BRANCH.
  - Wraps 0xFFFFFFFF -> 0. Not incremented on illegal_op or bus_error.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package riscv_ctrl_pkg:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE_ALU, OP_BRANCH);
  - ALUOp constants (ALUOP_ADD=000, ALUOP_SUB=001, ALUOP_FUNCT=010, ALUOP_OR=011);
  - FSM state enum (4-bit encoding).
- One natural sub-module: mem_wait_timer (counter plus timeout compare), reused for each memory state.

Test Plan:
- lb, opcode 0000011, mem_ready always 1:
  - states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB (5 cycles);
  - RegWrite=1 with MemtoReg=1 only in cycle 5; ALUOp=000 throughout.
- add (0110011) then ori (0010011):
  - ALUOp=010 in EXEC_R and 011 in EXEC_I;
  - RegWrite with MemtoReg=0 in the 4th cycle of each.
- bne (1100011):
  - with zero=0: PCWriteCond=1, PCSource=1 in cycle 3;
  - with zero=1: PCWriteCond=0; FETCH follows in both cases.
- sb with mem_ready held low 3 cycles in MEM_WRITE:
  - MemWrite held high for 4 cycles; one FETCH follows; RegWrite never asserted.
- FETCH with mem_ready=0 for 15 cycles (MEM_WAIT_MAX=15):
  - bus_error pulses once; IRWrite never asserted; FSM restarts FETCH with counter 0.
- opcode 1111111 in DECODE:
  - illegal_op pulses one cycle; FETCH next.
- rst_n pulsed low during MEM_READ:
  - state=FETCH immediately, RegWrite=0; with INSTRET_COUNTER_EN, instret=0.
